// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl: March C- memory BIST controller for a single-port memory.
// It sequences six March elements over addresses 0..ADDR_MAX and drives the
// address, write data and write/read strobe. Read data is checked against the
// expected value through a pipeline whose depth matches the memory read latency.
//
// Ports:
//   clk, rst_n      clock and synchronous active-low reset
//   start           level; starts a run from IDLE or DONE
//   busy            high from the first SETUP cycle through DRAIN
//   done, pass      end-of-run status; pass is valid while done is high
//   fail_addr/elem  address and March element of the first mismatch
//   fail_count      number of mismatching reads, saturating at 255
//   mem_*           memory port (1 = write); mem_rdata is registered read data
module mbist_march_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned ADDR_MAX   = 255,
    parameter int unsigned RD_LAT     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_elem,
    output logic [7:0]            fail_count,
    output logic                  mem_write_read,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [ADDR_WIDTH-1:0] AddrLast  = ADDR_WIDTH'(ADDR_MAX);
    localparam int unsigned           CntW      = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CntW-1:0]       DrainLast = CntW'(RD_LAT - 1);

    typedef enum logic [2:0] {StIdle, StSetup, StOps, StDrain, StDone} state_e;

    state_e                state_q, state_d;
    logic [2:0]            elem_q, elem_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  phase_q, phase_d;  // 0: read slot, 1: write slot
    logic [CntW-1:0]       drain_q, drain_d;
    logic                  clear_status;

    logic                  desc, has_read, has_write, last_addr, next_desc;
    logic [2:0]            elem_next;
    logic [DATA_WIDTH-1:0] wval, rexp;
    logic                  rd_issue, wr_issue, op_done, mismatch;

    logic [ADDR_WIDTH-1:0] fail_addr_q;
    logic [2:0]            fail_elem_q;
    logic [7:0]            fail_count_q;

    // Read-compare pipeline: entry [RD_LAT-1] lines up with mem_rdata.
    logic                  pvalid_q [RD_LAT];
    logic [DATA_WIDTH-1:0] pexp_q   [RD_LAT];
    logic [ADDR_WIDTH-1:0] paddr_q  [RD_LAT];
    logic [2:0]            pelem_q  [RD_LAT];

    // Per-element attributes of the March C- sequence.
    always_comb begin
        desc      = (elem_q == 3'd3) || (elem_q == 3'd4);
        has_read  = (elem_q != 3'd0);
        has_write = (elem_q != 3'd5);
        wval      = ((elem_q == 3'd1) || (elem_q == 3'd3)) ? '1 : '0;
        rexp      = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? '1 : '0;
        last_addr = desc ? (addr_q == '0) : (addr_q == AddrLast);
        elem_next = elem_q + 3'd1;
        next_desc = (elem_next == 3'd3) || (elem_next == 3'd4);
        rd_issue  = (state_q == StOps) && has_read && !phase_q;
        wr_issue  = (state_q == StOps) && has_write && (!has_read || phase_q);
        // Single-op elements finish an address every cycle.
        op_done   = !(has_read && has_write) || phase_q;
    end

    always_comb begin
        state_d      = state_q;
        elem_d       = elem_q;
        addr_d       = addr_q;
        phase_d      = phase_q;
        drain_d      = drain_q;
        clear_status = (state_q == StIdle);
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d      = StSetup;
                    elem_d       = 3'd0;
                    addr_d       = '0;
                    phase_d      = 1'b0;
                    clear_status = 1'b1;
                end
            end
            StSetup: begin
                state_d = StOps;
                phase_d = 1'b0;
            end
            StOps: begin
                if (!op_done) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (!last_addr) begin
                        addr_d = desc ? addr_q - 1'b1 : addr_q + 1'b1;
                    end else if (elem_q == 3'd5) begin
                        state_d = StDrain;
                        drain_d = '0;
                    end else begin
                        state_d = StSetup;
                        elem_d  = elem_next;
                        addr_d  = next_desc ? AddrLast : '0;
                    end
                end
            end
            StDrain: begin
                if (drain_q == DrainLast) state_d = StDone;
                else drain_d = drain_q + 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            elem_q  <= 3'd0;
            addr_q  <= '0;
            phase_q <= 1'b0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            addr_q  <= addr_d;
            phase_q <= phase_d;
            drain_q <= drain_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pvalid_q[i] <= 1'b0;
                pexp_q[i]   <= '0;
                paddr_q[i]  <= '0;
                pelem_q[i]  <= 3'd0;
            end
        end else begin
            pvalid_q[0] <= rd_issue;
            pexp_q[0]   <= rexp;
            paddr_q[0]  <= addr_q;
            pelem_q[0]  <= elem_q;
            for (int i = 1; i < RD_LAT; i++) begin
                pvalid_q[i] <= pvalid_q[i-1];
                pexp_q[i]   <= pexp_q[i-1];
                paddr_q[i]  <= paddr_q[i-1];
                pelem_q[i]  <= pelem_q[i-1];
            end
        end
    end

    assign mismatch = pvalid_q[RD_LAT-1] && (mem_rdata != pexp_q[RD_LAT-1]);

    always_ff @(posedge clk) begin
        if (!rst_n || clear_status) begin
            fail_addr_q  <= '0;
            fail_elem_q  <= 3'd0;
            fail_count_q <= 8'd0;
        end else if (mismatch) begin
            // A zero count means this is the first mismatch of the run.
            if (fail_count_q == 8'd0) begin
                fail_addr_q <= paddr_q[RD_LAT-1];
                fail_elem_q <= pelem_q[RD_LAT-1];
            end
            if (fail_count_q != 8'hFF) fail_count_q <= fail_count_q + 8'd1;
        end
    end

    assign busy           = (state_q == StSetup) || (state_q == StOps) || (state_q == StDrain);
    assign done           = (state_q == StDone);
    assign pass           = done && (fail_count_q == 8'd0);
    assign fail_addr      = fail_addr_q;
    assign fail_elem      = fail_elem_q;
    assign fail_count     = fail_count_q;
    assign mem_write_read = wr_issue;
    assign mem_address    = addr_q;
    // Held for the whole element, SETUP included, so it leads every write.
    assign mem_wdata      = wval;

endmodule
